exec_md_unit: RTL and testbench
===============================

# exec_md_unit

Parametrised execute-stage multiply/divide unit for the pipelined CPU, sitting beside the ALU in the Ex stage. It selects forwarded operands (EX/MEM, MEM/WB bypass), runs signed/unsigned multiply and divide iteratively over DATA_W cycles, and owns the HI/LO architectural registers. It also serves MTHI/MTLO/MFHI/MFLO and raises a stall to the hazard unit while an operation is in flight.

## Interface
- DATA_W, 32: operand/HI/LO width; even, ≥8.
- CNT_W, $clog2(DATA_W)+1: iteration counter width (derived).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- busA_Ex, busB_Ex  in  DATA_W each  register-file operands.
- Ex_Mem_ByPassing, Mem_Wr_ByPassing  in  DATA_W each  forwarded data.
- SrcA_ByPassing, SrcB_ByPassing  in  2 each  operand select: 00 bus, 01 Ex/Mem, 10 Mem/Wr, 11 bus.
- md_op_Ex  in  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NONE.
- mf_sel_Ex  in  1  0 read LO, 1 read HI.
- mf_rd_Ex  in  1  MFHI/MFLO in Ex this cycle.
- kill_Ex  in  1  flush; aborts the in-flight operation.
- hilo_out_Ex  out  DATA_W  mf_sel ? HI : LO, combinational from registers.
- md_stall_Ex  out  1  hold Ex and earlier stages.
- md_busy  out  1  iteration in progress.
- md_done  out  1  one-cycle pulse after HI/LO updated by MULT/DIV.

## Operation
- Operand A/B = 4:1 select per SrcX_ByPassing; the selected value is what is latched on accept.
- States: IDLE, RUN, FIX.
- IDLE: md_op in {MULT,MULTU,DIV,DIVU} and !kill_Ex → latch operand magnitudes (unsigned ops: raw), result-sign flags, count=0, → RUN.
- IDLE: MTHI/MTLO and !kill_Ex → HI or LO = operand A at the edge; stay IDLE.
- RUN: one radix-2 step per cycle (shift-add multiply, restoring divide over a 2·DATA_W accumulator); count increments; count==DATA_W-1 step → FIX.
- FIX: apply signs, write HI/LO, pulse md_done next cycle, → IDLE.
- Multiply: {HI,LO} = full 2·DATA_W product; negated if operand signs differ (signed only).
- Divide: LO = quotient, HI = remainder; quotient negated if signs differ, remainder takes the dividend's sign (truncating division).
- Divide by zero: HI = dividend (operand A as given), LO = all ones; same latency; no exception.
- Signed MIN / −1: LO = MIN, HI = 0 (falls out of the magnitude datapath).
- md_stall_Ex = md_busy & (md_op_Ex≠NONE | mf_rd_Ex); independent instructions do not stall.
- kill_Ex in RUN/FIX → IDLE at that edge; HI/LO unchanged, no md_done. kill_Ex in IDLE suppresses accept.

## Timing
- Reset (rst_n low at an edge): HI=0, LO=0, state IDLE, count 0, md_busy=0, md_done=0, md_stall_Ex=0; hilo_out_Ex=0.
- Accept at edge E0; md_busy high from after E0 until after E(DATA_W+1); HI/LO written at E(DATA_W+1); md_done high for the following cycle only.
- The earliest next accept is E(DATA_W+2); a stalled request is held by the pipeline and accepted on the first edge with md_busy=0.
- MFHI/MFLO in the cycle after FIX (or in the md_done cycle) returns the new value; MTHI at edge E → MF in the next cycle sees it.
- rst_n low mid-operation overrides everything, including kill_Ex.

## Structure
- Package exec_md_pkg: md_op encodings, bypass-select constants, state enum (IDLE/RUN/FIX).
- Sub-module muldiv_iter: the iterative datapath (accumulator, count, step logic, sign fix). The top level holds the bypass muxes, HI/LO, FSM control and stall.

## Test plan
- DATA_W=32, MULT A=0xFFFFFFFD (−3), B=5 → at E33 HI=0xFFFFFFFF, LO=0xFFFFFFF1; md_done high cycle 34 only; busy cycles 1–33.
- DIVU 100/7 → LO=14, HI=2. DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- DIV 0x1234/0 → HI=0x1234, LO=0xFFFFFFFF, normal latency.
- MULTU with SrcA=01 (Ex/Mem=0x10000), SrcB=10 (Mem/Wr=0x10000) → HI=1, LO=0; the bus values are ignored.
- Back-to-back MULT then MFLO: md_stall_Ex high while busy, MFLO returns the product in the md_done cycle; an unrelated NONE op during busy → no stall.
- kill_Ex at RUN cycle 10 → IDLE, HI/LO retain prior values, no md_done; rst_n low at RUN cycle 5 → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/exec_md_pkg.sv
// Shared encodings for the Ex-stage multiply/divide unit: md_op codes,
// bypass operand selects and FSM state codes.
package exec_md_pkg;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;
  localparam logic [2:0] MD_NONE7 = 3'b111;

  localparam logic [1:0] SRC_BUS   = 2'b00;
  localparam logic [1:0] SRC_EXMEM = 2'b01;
  localparam logic [1:0] SRC_MEMWR = 2'b10;
  localparam logic [1:0] SRC_BUS3  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_nop(input logic [2:0] op);
    return (op == MD_NONE) || (op == MD_NONE7);
  endfunction

endpackage

// File: rtl/exec_md_unit_if.sv
// Pipeline-facing bundle of the mul/div unit: operands, bypass data, op
// controls and HI/LO read-back / stall status. master = pipeline, slave = unit.
interface exec_md_unit_if #(parameter int DATA_W = 32);

  logic [DATA_W-1:0] busA_Ex;
  logic [DATA_W-1:0] busB_Ex;
  logic [DATA_W-1:0] Ex_Mem_ByPassing;
  logic [DATA_W-1:0] Mem_Wr_ByPassing;
  logic [1:0]        SrcA_ByPassing;
  logic [1:0]        SrcB_ByPassing;
  logic [2:0]        md_op_Ex;
  logic              mf_sel_Ex;
  logic              mf_rd_Ex;
  logic              kill_Ex;
  logic [DATA_W-1:0] hilo_out_Ex;
  logic              md_stall_Ex;
  logic              md_busy;
  logic              md_done;

  modport master (
    output busA_Ex, busB_Ex, Ex_Mem_ByPassing, Mem_Wr_ByPassing,
           SrcA_ByPassing, SrcB_ByPassing, md_op_Ex, mf_sel_Ex, mf_rd_Ex, kill_Ex,
    input  hilo_out_Ex, md_stall_Ex, md_busy, md_done
  );

  modport slave (
    input  busA_Ex, busB_Ex, Ex_Mem_ByPassing, Mem_Wr_ByPassing,
           SrcA_ByPassing, SrcB_ByPassing, md_op_Ex, mf_sel_Ex, mf_rd_Ex, kill_Ex,
    output hilo_out_Ex, md_stall_Ex, md_busy, md_done
  );

endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply/divide datapath on magnitudes with a final sign fix.
// One step per cycle for DATA_W cycles; no backpressure, the controller gates start/step.
module muldiv_iter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic              is_signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              last_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [DATA_W-1:0]   a_raw_q, a_raw_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic                div0_q, div0_d;

  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     add_sum;
  logic [DATA_W:0]     div_tmp;
  logic                div_ge;
  logic [DATA_W-1:0]   div_rem;
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   rem_raw, quot_raw;

  always_comb begin
    a_neg = is_signed_i & a_i[DATA_W-1];
    b_neg = is_signed_i & b_i[DATA_W-1];
    a_mag = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag = b_neg ? (~b_i + 1'b1) : b_i;

    // Multiply: accumulate multiplicand into upper half, shift right with carry.
    add_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: shift next dividend bit into the partial remainder, restore on underflow.
    div_tmp = acc_q[2*DATA_W-1:DATA_W-1];
    div_ge  = (div_tmp >= {1'b0, opnd_q});
    div_rem = div_ge ? (div_tmp[DATA_W-1:0] - opnd_q) : div_tmp[DATA_W-1:0];

    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;

    if (start_i) begin
      acc_d     = {{DATA_W{1'b0}}, is_div_i ? a_mag : b_mag};
      opnd_d    = is_div_i ? b_mag : a_mag;
      a_raw_d   = a_i;
      cnt_d     = '0;
      is_div_d  = is_div_i;
      neg_d     = a_neg ^ b_neg;
      rem_neg_d = a_neg;
      div0_d    = (b_i == '0);
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_q)
        acc_d = {div_rem, acc_q[DATA_W-2:0], div_ge};
      else
        acc_d = {add_sum, acc_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(DATA_W - 1));

  // Divide by zero returns the dividend exactly as presented, not its magnitude.
  always_comb begin
    prod_s   = neg_q ? (~acc_q + 1'b1) : acc_q;
    rem_raw  = acc_q[2*DATA_W-1:DATA_W];
    quot_raw = acc_q[DATA_W-1:0];
    if (!is_div_q) begin
      hi_o = prod_s[2*DATA_W-1:DATA_W];
      lo_o = prod_s[DATA_W-1:0];
    end else if (div0_q) begin
      hi_o = a_raw_q;
      lo_o = '1;
    end else begin
      hi_o = rem_neg_q ? (~rem_raw + 1'b1) : rem_raw;
      lo_o = neg_q ? (~quot_raw + 1'b1) : quot_raw;
    end
  end

endmodule

// File: rtl/exec_md_unit.sv
// Ex-stage mul/div unit: bypass operand select, HI/LO registers, IDLE/RUN/FIX control.
// MULT/DIV take DATA_W+1 cycles; md_stall_Ex holds dependent Ex instructions while busy.
module exec_md_unit
  import exec_md_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input logic           clk,
  input logic           rst_n,
  exec_md_unit_if.slave md
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] opa, opb;
  logic              start, step, last;
  logic              op_div, op_signed;
  logic [DATA_W-1:0] res_hi, res_lo;

  always_comb begin
    case (md.SrcA_ByPassing)
      SRC_EXMEM: opa = md.Ex_Mem_ByPassing;
      SRC_MEMWR: opa = md.Mem_Wr_ByPassing;
      default:   opa = md.busA_Ex;
    endcase
    case (md.SrcB_ByPassing)
      SRC_EXMEM: opb = md.Ex_Mem_ByPassing;
      SRC_MEMWR: opb = md.Mem_Wr_ByPassing;
      default:   opb = md.busB_Ex;
    endcase
  end

  assign op_div    = (md.md_op_Ex == MD_DIV) || (md.md_op_Ex == MD_DIVU);
  assign op_signed = (md.md_op_Ex == MD_DIV) || (md.md_op_Ex == MD_MULT);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    start   = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!md.kill_Ex) begin
          if (is_iter_op(md.md_op_Ex)) begin
            start   = 1'b1;
            state_d = ST_RUN;
          end else if (md.md_op_Ex == MD_MTHI) begin
            hi_d = opa;
          end else if (md.md_op_Ex == MD_MTLO) begin
            lo_d = opa;
          end
        end
      end
      ST_RUN: begin
        if (md.kill_Ex) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (last) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!md.kill_Ex) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  muldiv_iter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .step_i      (step),
    .is_div_i    (op_div),
    .is_signed_i (op_signed),
    .a_i         (opa),
    .b_i         (opb),
    .last_o      (last),
    .hi_o        (res_hi),
    .lo_o        (res_lo)
  );

  assign md.md_busy     = (state_q != ST_IDLE);
  assign md.md_done     = done_q;
  assign md.md_stall_Ex = md.md_busy & (!is_nop(md.md_op_Ex) | md.mf_rd_Ex);
  assign md.hilo_out_Ex = md.mf_sel_Ex ? hi_q : lo_q;

endmodule

// File: tb/tb_exec_md_unit.sv
// Directed-vector bench for exec_md_unit with hand-computed HI/LO, latency and stall values.
module tb_exec_md_unit;
  import exec_md_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exec_md_unit_if #(.DATA_W(W)) md();

  exec_md_unit #(.DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
    md.mf_sel_Ex = 1'b1;
    #1 hi = md.hilo_out_Ex;
    md.mf_sel_Ex = 1'b0;
    #1 lo = md.hilo_out_Ex;
  endtask

  // Ticks until md_done, counting busy cycles; an expired bound shows as a latency miscompare.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (!md.md_done && cyc < 100) begin
      if (md.md_busy) busy_cnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic run_md(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int cyc, busy_cnt;
    logic [W-1:0] hi, lo;
    md.md_op_Ex = op;
    md.busA_Ex  = a;
    md.busB_Ex  = b;
    tick();
    md.md_op_Ex = MD_NONE;
    wait_done(cyc, busy_cnt);
    check({tag, " latency"}, 64'(cyc), 64'(W + 1));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
    read_hilo(hi, lo);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    tick();
    check({tag, " done_pulse"}, 64'(md.md_done), 64'(0));
  endtask

  initial begin
    int cyc, busy_cnt, done_seen;
    logic [W-1:0] hi, lo;

    md.busA_Ex = '0;
    md.busB_Ex = '0;
    md.Ex_Mem_ByPassing = '0;
    md.Mem_Wr_ByPassing = '0;
    md.SrcA_ByPassing = SRC_BUS;
    md.SrcB_ByPassing = SRC_BUS;
    md.md_op_Ex = MD_NONE;
    md.mf_sel_Ex = 1'b0;
    md.mf_rd_Ex = 1'b0;
    md.kill_Ex = 1'b0;

    // reset state
    tick();
    tick();
    check("rst busy", 64'(md.md_busy), 64'(0));
    check("rst done", 64'(md.md_done), 64'(0));
    md.mf_rd_Ex = 1'b1;
    #1 check("rst stall", 64'(md.md_stall_Ex), 64'(0));
    md.mf_rd_Ex = 1'b0;
    read_hilo(hi, lo);
    check("rst hi", 64'(hi), 64'(0));
    check("rst lo", 64'(lo), 64'(0));
    rst_n = 1'b1;
    tick();

    // MTHI / MTLO visible in the following cycle
    md.md_op_Ex = MD_MTHI;
    md.busA_Ex  = 32'h0000_AAAA;
    tick();
    md.md_op_Ex = MD_MTLO;
    md.busA_Ex  = 32'h0000_5555;
    tick();
    md.md_op_Ex = MD_NONE;
    read_hilo(hi, lo);
    check("mthi", 64'(hi), 64'h0000_AAAA);
    check("mtlo", 64'(lo), 64'h0000_5555);

    run_md("mult_neg3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_md("div_by0", MD_DIV, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_md("div_neg_by0", MD_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // bypass selects override the register-file buses
    md.SrcA_ByPassing   = SRC_EXMEM;
    md.SrcB_ByPassing   = SRC_MEMWR;
    md.Ex_Mem_ByPassing = 32'h0001_0000;
    md.Mem_Wr_ByPassing = 32'h0001_0000;
    run_md("bypass_multu", MD_MULTU, 32'h0000_DEAD, 32'h0000_BEEF, 32'h1, 32'h0);
    md.SrcA_ByPassing = SRC_BUS;
    md.SrcB_ByPassing = SRC_BUS;

    // stall behaviour and back-to-back issue from the md_done cycle
    md.md_op_Ex = MD_MULT;
    md.busA_Ex  = 32'd7;
    md.busB_Ex  = 32'd6;
    tick();
    md.md_op_Ex = MD_NONE;
    md.mf_rd_Ex = 1'b1;
    #1 check("stall mf_rd", 64'(md.md_stall_Ex), 64'(1));
    md.mf_rd_Ex = 1'b0;
    #1 check("stall none", 64'(md.md_stall_Ex), 64'(0));
    md.md_op_Ex = MD_NONE7;
    #1 check("stall none7", 64'(md.md_stall_Ex), 64'(0));
    md.md_op_Ex = MD_MTLO;
    #1 check("stall mtlo", 64'(md.md_stall_Ex), 64'(1));
    md.md_op_Ex = MD_NONE;
    wait_done(cyc, busy_cnt);
    check("b2b latency", 64'(cyc), 64'(W + 1));
    md.mf_rd_Ex  = 1'b1;
    md.mf_sel_Ex = 1'b0;
    #1 check("mflo in done cycle", 64'(md.hilo_out_Ex), 64'd42);
    check("no stall in done cycle", 64'(md.md_stall_Ex), 64'(0));
    md.mf_rd_Ex = 1'b0;
    md.md_op_Ex = MD_DIVU;
    md.busA_Ex  = 32'd100;
    md.busB_Ex  = 32'd7;
    tick();
    md.md_op_Ex = MD_NONE;
    check("b2b accept", 64'(md.md_busy), 64'(1));
    wait_done(cyc, busy_cnt);
    check("b2b div latency", 64'(cyc), 64'(W + 1));
    read_hilo(hi, lo);
    check("b2b div lo", 64'(lo), 64'd14);
    tick();

    // kill mid-RUN: HI/LO keep their prior values and no done pulse
    md.md_op_Ex = MD_MTHI;
    md.busA_Ex  = 32'h0000_1111;
    tick();
    md.md_op_Ex = MD_MTLO;
    md.busA_Ex  = 32'h0000_2222;
    tick();
    md.md_op_Ex = MD_MULT;
    md.busA_Ex  = 32'd3;
    md.busB_Ex  = 32'd5;
    tick();
    md.md_op_Ex = MD_NONE;
    repeat (10) tick();
    md.kill_Ex = 1'b1;
    tick();
    md.kill_Ex = 1'b0;
    check("kill busy", 64'(md.md_busy), 64'(0));
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (md.md_done) done_seen++;
      tick();
    end
    check("kill no done", 64'(done_seen), 64'(0));
    read_hilo(hi, lo);
    check("kill hi", 64'(hi), 64'h0000_1111);
    check("kill lo", 64'(lo), 64'h0000_2222);

    // kill in IDLE suppresses accept
    md.md_op_Ex = MD_DIV;
    md.kill_Ex  = 1'b1;
    tick();
    md.md_op_Ex = MD_NONE;
    md.kill_Ex  = 1'b0;
    check("kill idle no accept", 64'(md.md_busy), 64'(0));

    // reset mid-RUN overrides kill and restores reset values
    md.md_op_Ex = MD_MULT;
    md.busA_Ex  = 32'd3;
    md.busB_Ex  = 32'd5;
    tick();
    md.md_op_Ex = MD_NONE;
    repeat (4) tick();
    rst_n = 1'b0;
    md.kill_Ex = 1'b1;
    tick();
    md.kill_Ex = 1'b0;
    check("midrst busy", 64'(md.md_busy), 64'(0));
    check("midrst done", 64'(md.md_done), 64'(0));
    md.mf_rd_Ex = 1'b1;
    #1 check("midrst stall", 64'(md.md_stall_Ex), 64'(0));
    md.mf_rd_Ex = 1'b0;
    read_hilo(hi, lo);
    check("midrst hi", 64'(hi), 64'(0));
    check("midrst lo", 64'(lo), 64'(0));
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
